vga_timing_gen: RTL and testbench

Upstream stage of the sprite/colour renderer. Generates 640x480@60 Hz VGA timing from the 100 MHz board clock. Produces the hCount/vCount/bright raster the renderer consumes, plus hSync/vSync for the VGA connector. Also produces single-cycle pixel, line and frame strobes for game-logic pacing.

---
 rtl/vga_timing_gen_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen_pixel_en_gen.sv | 27 ++
 rtl/vga_timing_gen.sv | 90 +++++++++
 tb/tb_vga_timing_gen.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the 640x480@60 Hz raster generator: geometry,
// default pixel-clock divide ratio and the counter width.
package vga_timing_pkg;

  localparam int CNT_W       = 10;
  localparam int CLK_DIV_DEF = 4;

  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 784;

  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 515;

  typedef logic [CNT_W-1:0] cnt_t;

  // Half-open interval test lo <= c < hi on raster counts.
  function automatic logic in_span(cnt_t c, cnt_t lo, cnt_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the renderer / VGA pins.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic pix_en;
  cnt_t hCount;
  cnt_t vCount;
  logic bright;
  logic hSync;
  logic vSync;
  logic line_start;
  logic frame_start;

  modport master (
    output pix_en, hCount, vCount, bright, hSync, vSync, line_start, frame_start
  );

  modport slave (
    input pix_en, hCount, vCount, bright, hSync, vSync, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_pixel_en_gen.sv
// Board-clock divider producing a registered one-clock pixel strobe.
module pixel_en_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // Free-running 0..CLK_DIV-1 counter; strobe is registered so it lands
  // in the cycle after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      pix_en <= (div == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters advanced by the pixel strobe, with
// sync/bright decoded from next-state counts so they stay aligned with
// hCount/vCount, plus line/frame start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam cnt_t H_LAST = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_LAST = CNT_W'(V_TOTAL - 1);
  localparam cnt_t H_SE   = CNT_W'(H_SYNC);
  localparam cnt_t V_SE   = CNT_W'(V_SYNC);
  localparam cnt_t H_A0   = CNT_W'(H_ACT_START);
  localparam cnt_t H_A1   = CNT_W'(H_ACT_END);
  localparam cnt_t V_A0   = CNT_W'(V_ACT_START);
  localparam cnt_t V_A1   = CNT_W'(V_ACT_END);

  logic pix_en;
  cnt_t h_cnt, v_cnt;
  cnt_t h_nxt, v_nxt;
  logic h_wrap, v_wrap;
  logic bright, hsync, vsync, line_start, frame_start;

  pixel_en_gen #(.CLK_DIV(CLK_DIV)) u_pix (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  // Next-state raster position; equality wrap so counts never overflow.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (pix_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_nxt = h_cnt + CNT_W'(1);
      end
    end
  end

  // Counters and decode registered together so every raster output
  // changes on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bright      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      bright      <= in_span(h_nxt, H_A0, H_A1) && in_span(v_nxt, V_A0, V_A1);
      hsync       <= (h_nxt >= H_SE);
      vsync       <= (v_nxt >= V_SE);
      line_start  <= pix_en && h_wrap;
      frame_start <= pix_en && h_wrap && v_wrap;
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.hCount      = h_cnt;
  assign vga.vCount      = v_cnt;
  assign vga.bright      = bright;
  assign vga.hSync       = hsync;
  assign vga.vSync       = vsync;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full 640x480 instance and a shrunken-geometry
// instance share clock and reset; both are compared every cycle against a
// closed-form model of position versus clocks elapsed since reset release.
module tb_vga_timing_gen;

  // Full-size geometry, written out independently of the design package.
  localparam int F_D = 4,  F_HT = 800, F_HS = 96, F_HA0 = 144, F_HA1 = 784;
  localparam int F_VT = 525, F_VS = 2, F_VA0 = 35, F_VA1 = 515;
  // Small geometry so whole frames fit in a short run.
  localparam int S_D = 2,  S_HT = 40, S_HS = 6, S_HA0 = 9, S_HA1 = 37;
  localparam int S_VT = 20, S_VS = 2, S_VA0 = 4, S_VA1 = 18;
  localparam int S_FRAME  = S_D * S_HT * S_VT;
  localparam int S_BRIGHT = (S_HA1 - S_HA0) * (S_VA1 - S_VA0);

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       b, hs, vs, ls, fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   k;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_fs;
  int   bcnt;

  always #5 clk = ~clk;

  vga_timing_gen_if vif_f();
  vga_timing_gen_if vif_s();

  vga_timing_gen u_full (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif_f)
  );

  vga_timing_gen #(
    .CLK_DIV(S_D), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HA0),
    .H_ACT_END(S_HA1), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_START(S_VA0),
    .V_ACT_END(S_VA1)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Expected outputs after the kk-th clock edge since release (0 = in reset).
  // A pixel step happens on edges D+1, 2D+1, ...; pix_en is high after
  // every D-th edge.
  function automatic exp_t model(int kk, int d, int ht, int hs, int ha0, int ha1,
                                 int vt, int vs, int va0, int va1);
    exp_t e;
    int   n, h, v;
    logic adv;
    e = '0;
    if (kk > 0) begin
      n   = (kk - 1) / d;
      adv = (kk > 1) && ((kk - 1) % d == 0);
      h   = n % ht;
      v   = (n / ht) % vt;
      e.pe = (kk % d == 0);
      e.h  = 10'(h);
      e.v  = 10'(v);
      e.b  = (h >= ha0) && (h < ha1) && (v >= va0) && (v < va1);
      e.hs = (h >= hs);
      e.vs = (v >= vs);
      e.ls = adv && (h == 0);
      e.fs = adv && (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic cmp_inst(input string nm, input exp_t e, input logic pe,
                          input logic [9:0] h, input logic [9:0] v, input logic b,
                          input logic hs, input logic vs, input logic ls,
                          input logic fs);
    chk({nm, ".pix_en"},      int'(pe), int'(e.pe));
    chk({nm, ".hCount"},      int'(h),  int'(e.h));
    chk({nm, ".vCount"},      int'(v),  int'(e.v));
    chk({nm, ".bright"},      int'(b),  int'(e.b));
    chk({nm, ".hSync"},       int'(hs), int'(e.hs));
    chk({nm, ".vSync"},       int'(vs), int'(e.vs));
    chk({nm, ".line_start"},  int'(ls), int'(e.ls));
    chk({nm, ".frame_start"}, int'(fs), int'(e.fs));
  endtask

  task automatic check_all();
    exp_t ef, es;
    ef = model(k, F_D, F_HT, F_HS, F_HA0, F_HA1, F_VT, F_VS, F_VA0, F_VA1);
    es = model(k, S_D, S_HT, S_HS, S_HA0, S_HA1, S_VT, S_VS, S_VA0, S_VA1);
    cmp_inst("full", ef, vif_f.pix_en, vif_f.hCount, vif_f.vCount, vif_f.bright,
             vif_f.hSync, vif_f.vSync, vif_f.line_start, vif_f.frame_start);
    cmp_inst("small", es, vif_s.pix_en, vif_s.hCount, vif_s.vCount, vif_s.bright,
             vif_s.hSync, vif_s.vSync, vif_s.line_start, vif_s.frame_start);
    if (vif_s.pix_en && vif_s.bright) bcnt++;
    if (vif_s.frame_start) begin
      if (last_fs > 0) begin
        chk("small.frame_period", k - last_fs, S_FRAME);
        chk("small.bright_per_frame", bcnt, S_BRIGHT);
      end
      last_fs = k;
      bcnt    = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    else       k = 0;
    @(negedge clk);
    check_all();
  endtask

  // Called at a falling edge: asserts reset mid-cycle and checks the
  // asynchronous clear before the next rising edge.
  task automatic do_reset(input int cycles);
    #2 rst_n = 1'b0;
    k       = 0;
    last_fs = 0;
    bcnt    = 0;
    #1 check_all();
    repeat (cycles) step();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    rst_n   = 1'b0;
    k       = 0;
    last_fs = 0;
    bcnt    = 0;
    repeat (3) step();
    #2 rst_n = 1'b1;

    // Long uninterrupted run: covers two full-size lines (vSync rise at
    // line 2) and several small frames.
    repeat (7000) step();

    // Reset in the middle of a small-instance frame.
    guard = 0;
    while (!(vif_s.hCount == 10'd20 && vif_s.vCount == 10'd10) && guard < 2000) begin
      step();
      guard++;
    end
    chk("small.reach_20_10", int'(guard < 2000), 1);
    do_reset(3);

    // Random run lengths interleaved with random-length resets.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(2500, 200)) step();
      do_reset($urandom_range(3, 1));
    end

    // Enough for two complete small frames after the last release.
    repeat (3400) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
